uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 123 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind the UART receiver.
// Each completed character is captured on the receiver's one-cycle rx_new
// strobe, together with its parity and frame error flags. The characters sit
// in a first-word-fall-through FIFO, and the consumer reads them over a
// valid/ready handshake.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rx_data, rx_err_parity,
//   rx_err_frame, rx_new        character input from the receiver (push on rx_new)
//   rd_valid, rd_ready          consumer handshake (pop on rd_valid & rd_ready)
//   rd_data, rd_err_parity,
//   rd_err_frame                head entry (valid only while rd_valid=1)
//   level, almost_full          fill level, and level >= AF_LEVEL
//   overrun, overrun_clr        sticky lost-character flag and its clear pulse
//   drop_cnt                    errored characters discarded (DROP_ERR=1), saturating
module uart_rx_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned AF_LEVEL   = 12,
  parameter int unsigned DROP_ERR   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_err_parity,
  input  logic                  rx_err_frame,
  input  logic                  rx_new,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_err_parity,
  output logic                  rd_err_frame,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic [7:0]            drop_cnt
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] AF_LVL    = AF_LEVEL[DEPTH_LOG2:0];

  // Each entry is {frame_err, parity_err, data[7:0]}
  logic [9:0]            mem_q [DEPTH];
  logic [9:0]            head;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            drop_cnt_q, drop_cnt_d;

  logic full;
  logic pop;
  logic drop;
  logic push_req;
  logic accept;

  always_comb begin
    full     = (level_q == DEPTH_LVL);
    pop      = rd_valid & rd_ready;
    drop     = rx_new & (DROP_ERR != 0) & (rx_err_parity | rx_err_frame);
    push_req = rx_new & ~drop;
    // When full, a same-cycle pop frees the slot the write pointer aims at.
    accept   = push_req & (~full | pop);
  end

  always_comb begin
    wptr_d     = accept ? wptr_q + DEPTH_LOG2'(1) : wptr_q;
    rptr_d     = pop    ? rptr_q + DEPTH_LOG2'(1) : rptr_q;
    level_d    = level_q;
    unique case ({accept, pop})
      2'b10:   level_d = level_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   level_d = level_q - (DEPTH_LOG2 + 1)'(1);
      default: level_d = level_q;
    endcase
    // A new loss takes priority over a clear in the same cycle.
    if (push_req && full && !pop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; only entries below level are ever presented.
  // A write never targets the head slot while it is still being presented,
  // so rd_data is stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wptr_q] <= {rx_err_frame, rx_err_parity, rx_data};
    end
  end

  assign head          = mem_q[rptr_q];
  assign rd_valid      = (level_q != '0);
  assign rd_data       = head[7:0];
  assign rd_err_parity = head[8];
  assign rd_err_frame  = head[9];
  assign level         = level_q;
  assign almost_full   = (level_q >= AF_LVL);
  assign overrun       = overrun_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Two instances share the stimulus:
// index 0 stores errored characters, and index 1 drops them.
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_err_parity;
  logic       rx_err_frame;
  logic       rx_new;
  logic       rd_ready;
  logic       overrun_clr;

  logic       rdv  [2];
  logic [7:0] rdd  [2];
  logic       rdp  [2];
  logic       rdf  [2];
  logic [4:0] lvl  [2];
  logic       af   [2];
  logic       ovr  [2];
  logic [7:0] dcnt [2];

  int n_chk;
  int n_fail;
  bit chk_en;

  // Behavioural model: one queue per instance, plus flags.
  logic [9:0] mq [2][$];
  bit         m_ovr  [2];
  int         m_drop [2];

  uart_rx_fifo #(.DEPTH_LOG2(4), .AF_LEVEL(12), .DROP_ERR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_err_parity(rx_err_parity),
    .rx_err_frame(rx_err_frame), .rx_new(rx_new), .rd_valid(rdv[0]), .rd_ready(rd_ready),
    .rd_data(rdd[0]), .rd_err_parity(rdp[0]), .rd_err_frame(rdf[0]), .level(lvl[0]),
    .almost_full(af[0]), .overrun(ovr[0]), .overrun_clr(overrun_clr), .drop_cnt(dcnt[0])
  );

  uart_rx_fifo #(.DEPTH_LOG2(4), .AF_LEVEL(12), .DROP_ERR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_err_parity(rx_err_parity),
    .rx_err_frame(rx_err_frame), .rx_new(rx_new), .rd_valid(rdv[1]), .rd_ready(rd_ready),
    .rd_data(rdd[1]), .rd_err_parity(rdp[1]), .rd_err_frame(rdf[1]), .level(lvl[1]),
    .almost_full(af[1]), .overrun(ovr[1]), .overrun_clr(overrun_clr), .drop_cnt(dcnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model update on each clock edge, using the inputs present before the edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        m_ovr[k]  = 1'b0;
        m_drop[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int  sz;
        bit  popm, errm, acc, lost;
        sz   = mq[k].size();
        popm = (sz > 0) && rd_ready;
        errm = rx_err_parity || rx_err_frame;
        acc  = 1'b0;
        lost = 1'b0;
        if (rx_new) begin
          if (k == 1 && errm) begin
            if (m_drop[k] < 255) m_drop[k]++;
          end else if (sz < 16 || popm) begin
            acc = 1'b1;
          end else begin
            lost = 1'b1;
          end
        end
        if (popm) void'(mq[k].pop_front());
        if (acc) mq[k].push_back({rx_err_frame, rx_err_parity, rx_data});
        if (lost) m_ovr[k] = 1'b1;
        else if (overrun_clr) m_ovr[k] = 1'b0;
      end
    end
  end

  // Compare process: compares the DUT outputs with the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        int sz;
        sz = mq[k].size();
        chk($sformatf("cmp%0d.rd_valid", k), 32'(rdv[k]), 32'(sz > 0));
        chk($sformatf("cmp%0d.level", k), 32'(lvl[k]), 32'(sz));
        chk($sformatf("cmp%0d.almost_full", k), 32'(af[k]), 32'(sz >= 12));
        chk($sformatf("cmp%0d.overrun", k), 32'(ovr[k]), 32'(m_ovr[k]));
        chk($sformatf("cmp%0d.drop_cnt", k), 32'(dcnt[k]), 32'(m_drop[k]));
        if (sz > 0) begin
          chk($sformatf("cmp%0d.rd_data", k), 32'(rdd[k]), 32'(mq[k][0][7:0]));
          chk($sformatf("cmp%0d.rd_err_parity", k), 32'(rdp[k]), 32'(mq[k][0][8]));
          chk($sformatf("cmp%0d.rd_err_frame", k), 32'(rdf[k]), 32'(mq[k][0][9]));
        end
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic p, input logic f);
    rx_data       = d;
    rx_err_parity = p;
    rx_err_frame  = f;
    rx_new        = 1'b1;
    @(negedge clk);
    rx_new        = 1'b0;
    rx_err_parity = 1'b0;
    rx_err_frame  = 1'b0;
  endtask

  task automatic drain16_ready;
    rd_ready = 1'b1;
    repeat (16) @(negedge clk);
    rd_ready = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; chk_en = 1'b0;
    rst_n = 1'b0; rx_data = '0; rx_err_parity = 1'b0; rx_err_frame = 1'b0;
    rx_new = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset.rd_valid", 32'(rdv[0]), 32'd0);
    chk("reset.level", 32'(lvl[0]), 32'd0);
    chk("reset.overrun", 32'(ovr[0]), 32'd0);
    chk("reset.drop_cnt", 32'(dcnt[1]), 32'd0);

    // Single character, with latency of one cycle.
    push(8'h41, 1'b0, 1'b0);
    chk("single.rd_valid", 32'(rdv[0]), 32'd1);
    chk("single.rd_data", 32'(rdd[0]), 32'h41);
    chk("single.level", 32'(lvl[0]), 32'd1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("single.pop_valid", 32'(rdv[0]), 32'd0);
    chk("single.pop_level", 32'(lvl[0]), 32'd0);

    // Fill to full, then overrun, then drain in order.
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0, 1'b0);
      chk("fill.almost_full", 32'(af[0]), 32'(i + 1 >= 12));
    end
    chk("fill.level", 32'(lvl[0]), 32'd16);
    push(8'hAA, 1'b0, 1'b0);
    chk("ovr.overrun", 32'(ovr[0]), 32'd1);
    chk("ovr.level", 32'(lvl[0]), 32'd16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain.rd_data", 32'(rdd[0]), 32'(i));
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("drain.level", 32'(lvl[0]), 32'd0);

    // Clear overrun, then push and pop in the same cycle while full.
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("clr.overrun", 32'(ovr[0]), 32'd0);
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0, 1'b0);
    rx_data = 8'h99; rx_new = 1'b1; rd_ready = 1'b1;
    @(negedge clk);
    rx_new = 1'b0; rd_ready = 1'b0;
    chk("fullpp.overrun", 32'(ovr[0]), 32'd0);
    chk("fullpp.level", 32'(lvl[0]), 32'd16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("fullpp.rd_data", 32'(rdd[0]), (i < 15) ? 32'(8'h21 + i) : 32'h99);
      @(negedge clk);
    end
    rd_ready = 1'b0;

    // Error flags: stored by dut0, dropped by dut1.
    push(8'h55, 1'b0, 1'b1);
    push(8'h66, 1'b1, 1'b0);
    chk("err.head_data", 32'(rdd[0]), 32'h55);
    chk("err.head_frame", 32'(rdf[0]), 32'd1);
    chk("err.head_parity", 32'(rdp[0]), 32'd0);
    chk("err.drop_level", 32'(lvl[1]), 32'd0);
    chk("err.drop_cnt", 32'(dcnt[1]), 32'd2);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("err.next_data", 32'(rdd[0]), 32'h66);
    chk("err.next_frame", 32'(rdf[0]), 32'd0);
    chk("err.next_parity", 32'(rdp[0]), 32'd1);
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;

    // Overrun set wins over a clear in the same cycle.
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i), 1'b0, 1'b0);
    push(8'hBB, 1'b0, 1'b0);
    chk("setwin.pre", 32'(ovr[0]), 32'd1);
    rx_data = 8'hCC; rx_new = 1'b1; overrun_clr = 1'b1;
    @(negedge clk);
    rx_new = 1'b0; overrun_clr = 1'b0;
    chk("setwin.overrun", 32'(ovr[0]), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("clralone.overrun", 32'(ovr[0]), 32'd0);
    drain16_ready();

    // Randomized traffic, with the fill pressure varying per block.
    for (int b = 0; b < 15; b++) begin
      int rp, wp;
      rp = int'($urandom_range(90, 10));
      wp = int'($urandom_range(90, 20));
      for (int c = 0; c < 200; c++) begin
        rx_new        = (int'($urandom_range(99, 0)) < wp);
        rx_data       = 8'($urandom);
        rx_err_parity = (int'($urandom_range(99, 0)) < 20);
        rx_err_frame  = (int'($urandom_range(99, 0)) < 15);
        rd_ready      = (int'($urandom_range(99, 0)) < rp);
        overrun_clr   = (int'($urandom_range(99, 0)) < 3);
        @(negedge clk);
      end
    end
    rx_new = 1'b0; rx_err_parity = 1'b0; rx_err_frame = 1'b0;
    rd_ready = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of the stream.
    for (int i = 0; i < 20; i++) push(8'(8'h70 + i), 1'b0, 1'b0);
    chk("arst.pre_level", 32'(lvl[0]), 32'd16);
    chk("arst.pre_overrun", 32'(ovr[0]), 32'd1);
    rx_data = 8'hE5; rx_new = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst.rd_valid", 32'(rdv[k]), 32'd0);
      chk("arst.level", 32'(lvl[k]), 32'd0);
      chk("arst.overrun", 32'(ovr[k]), 32'd0);
      chk("arst.drop_cnt", 32'(dcnt[k]), 32'd0);
    end
    @(negedge clk);
    rx_new = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h5A, 1'b0, 1'b0);
    chk("post.rd_data", 32'(rdd[0]), 32'h5A);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
